// File: rtl/sdft_scale_pkg.sv
// Shared types for the SDFT automatic scaling controller.
package sdft_scale_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        DECIDE = 2'd2,
        HOLD   = 2'd3
    } state_t;

endpackage

// File: rtl/sdft_win_cnt.sv
// Observation window counter: counts valid samples and qualified saturation alarms,
// and flags the sample that completes the window.
module sdft_win_cnt #(
    parameter int WIN_LEN = 1024,
    localparam int CNT_W  = $clog2(WIN_LEN + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr,
    input  logic             cnt_en,
    input  logic             valid_i,
    input  logic             sat_alarm_i,
    output logic [CNT_W-1:0] sat_cnt,
    output logic             win_done
);

    logic [CNT_W-1:0] smp_cnt;

    assign win_done = cnt_en && valid_i && (smp_cnt == CNT_W'(WIN_LEN - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            smp_cnt <= '0;
            sat_cnt <= '0;
        end else if (clr) begin
            smp_cnt <= '0;
            sat_cnt <= '0;
        end else if (cnt_en && valid_i) begin
            smp_cnt <= smp_cnt + 1'b1;
            if (sat_alarm_i && (sat_cnt != '1))
                sat_cnt <= sat_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sdft_scale_ctrl.sv
// SDFT automatic scaling controller: steps the pre-saturation right-shift per window statistics.
// Optional SDFT_SCALE_STATS_EN adds last-window and peak saturation count outputs.
//
//  state  | meaning
//  IDLE   | disabled; shift held, counters clear
//  ACCUM  | collecting one window of valid samples
//  DECIDE | one cycle: compare window sat count, step shift
//  HOLD   | HOLDOFF cycles of pipeline flush after a shift change
module sdft_scale_ctrl
    import sdft_scale_pkg::*;
#(
    parameter int WIN_LEN   = 1024,
    parameter int HI_THR    = 4,
    parameter int QUIET_WIN = 8,
    parameter int HOLDOFF   = 64,
    parameter int SHIFT_W   = 3,
    parameter int MAX_SHIFT = 7,
    localparam int CNT_W    = $clog2(WIN_LEN + 1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               en_i,
    input  logic               valid_i,
    input  logic               sat_alarm_i,
    output logic [SHIFT_W-1:0] shift_o,
    output logic               shift_upd_o,
    output logic [1:0]         state_o
`ifdef SDFT_SCALE_STATS_EN
    ,
    output logic [CNT_W-1:0]   sat_cnt_o,
    output logic [CNT_W-1:0]   sat_peak_o
`endif
);

    localparam int Q_W = $clog2(QUIET_WIN + 1);
    localparam int H_W = $clog2(HOLDOFF + 1);

    state_t             state_q, state_d;
    logic [SHIFT_W-1:0] shift_q, shift_d;
    logic               upd_q, upd_d;
    logic [Q_W-1:0]     quiet_q, quiet_d;
    logic [H_W-1:0]     hold_q, hold_d;
    logic [CNT_W-1:0]   sat_cnt;
    logic               win_done;

    sdft_win_cnt #(.WIN_LEN(WIN_LEN)) u_win_cnt (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clr         (state_q != ACCUM || !en_i),
        .cnt_en      (state_q == ACCUM && en_i),
        .valid_i     (valid_i),
        .sat_alarm_i (sat_alarm_i),
        .sat_cnt     (sat_cnt),
        .win_done    (win_done)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            shift_q <= '0;
            upd_q   <= 1'b0;
            quiet_q <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            upd_q   <= upd_d;
            quiet_q <= quiet_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        upd_d   = 1'b0;
        quiet_d = quiet_q;
        hold_d  = hold_q;
        if (!en_i) begin
            state_d = IDLE;
            quiet_d = '0;
            hold_d  = '0;
        end else begin
            case (state_q)
                IDLE:   state_d = ACCUM;
                ACCUM:  if (win_done) state_d = DECIDE;
                DECIDE: begin
                    state_d = ACCUM;
                    if (sat_cnt >= CNT_W'(HI_THR)) begin
                        quiet_d = '0;
                        if (shift_q < SHIFT_W'(MAX_SHIFT)) begin
                            shift_d = shift_q + 1'b1;
                            upd_d   = 1'b1;
                            state_d = HOLD;
                            hold_d  = H_W'(HOLDOFF - 1);
                        end
                    end else if (sat_cnt == '0) begin
                        if (quiet_q == Q_W'(QUIET_WIN - 1)) begin
                            quiet_d = '0;
                            if (shift_q != '0) begin
                                shift_d = shift_q - 1'b1;
                                upd_d   = 1'b1;
                                state_d = HOLD;
                                hold_d  = H_W'(HOLDOFF - 1);
                            end
                        end else begin
                            quiet_d = quiet_q + 1'b1;
                        end
                    end else begin
                        quiet_d = '0;
                    end
                end
                HOLD: begin
                    if (hold_q == '0) state_d = ACCUM;
                    else              hold_d  = hold_q - 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign shift_o     = shift_q;
    assign shift_upd_o = upd_q;
    assign state_o     = state_q;

`ifdef SDFT_SCALE_STATS_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sat_cnt_o  <= '0;
            sat_peak_o <= '0;
        end else if (state_q == DECIDE) begin
            sat_cnt_o <= sat_cnt;
            if (sat_cnt > sat_peak_o)
                sat_peak_o <= sat_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_sdft_scale_ctrl.sv
// Scoreboard bench for sdft_scale_ctrl: expected shift pulses (value and cycle) are queued
// by the stimulus and popped by a monitor on every shift_upd_o pulse.
module tb_sdft_scale_ctrl;

    localparam int WIN = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       valid = 1'b0;
    logic       sat = 1'b0;
    logic [2:0] shift;
    logic       upd;
    logic [1:0] state;
`ifdef SDFT_SCALE_STATS_EN
    logic [4:0] sat_cnt_o;
    logic [4:0] sat_peak_o;
`endif

    sdft_scale_ctrl #(
        .WIN_LEN(WIN), .HI_THR(2), .QUIET_WIN(2), .HOLDOFF(4), .SHIFT_W(3), .MAX_SHIFT(3)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .en_i        (en),
        .valid_i     (valid),
        .sat_alarm_i (sat),
        .shift_o     (shift),
        .shift_upd_o (upd),
        .state_o     (state)
`ifdef SDFT_SCALE_STATS_EN
        ,
        .sat_cnt_o   (sat_cnt_o),
        .sat_peak_o  (sat_peak_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int shift;
        int cyc;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every shift_upd_o pulse must match the head of the scoreboard queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && upd) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: got shift %0d at cycle %0d, expected no pulse", shift, cyc);
                end else begin
                    e = sbq.pop_front();
                    check("pulse_shift", int'(shift), e.shift);
                    check("pulse_cycle", cyc, e.cyc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // One full window; n_sat of the WIN valids carry a sat alarm. exp_shift<0: no pulse.
    task automatic window(input int n_sat, input int exp_shift);
        exp_t e;
        for (int i = 0; i < WIN; i++) begin
            valid = 1'b1;
            sat   = (i < n_sat);
            last_cyc = cyc;
            tick();
        end
        valid = 1'b0;
        sat   = 1'b0;
        if (exp_shift >= 0) begin
            e.shift = exp_shift;
            e.cyc   = last_cyc + 2;
            sbq.push_back(e);
        end
    endtask

    task automatic win_gap(input int n_sat, input int exp_shift);
        window(n_sat, exp_shift);
        gap(8);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #23;
        check("rst_shift", int'(shift), 0);
        check("rst_upd", int'(upd), 0);
        check("rst_state", int'(state), 0);
        rst = 1'b0;
        tick();
        en = 1'b1;
        gap(2);
        check("en_accum", int'(state), 1);

        // 1: overload window, then sat-laden samples during DECIDE/HOLD must be ignored
        window(2, 1);
        valid = 1'b1;
        sat   = 1'b1;
        tick();
        check("hold_state", int'(state), 3);
        check("hold_shift", int'(shift), 1);
        gap(3);
        valid = 1'b0;
        sat   = 1'b0;
        tick();
        check("post_hold_accum", int'(state), 1);
        win_gap(0, -1);
        win_gap(1, -1);

        // 2: climb to MAX_SHIFT and stay there
        win_gap(2, 2);
        win_gap(2, 3);
        win_gap(2, -1);
        win_gap(16, -1);
        check("max_shift", int'(shift), 3);

        // 3: quiet windows step down; a 1-sat window clears the quiet run
        win_gap(0, -1);
        win_gap(0, 2);
        win_gap(0, -1);
        win_gap(0, 1);
        win_gap(0, -1);
        win_gap(1, -1);
        win_gap(0, -1);
        check("quiet_cleared", int'(shift), 1);
        win_gap(0, 0);
        win_gap(0, -1);
        win_gap(0, -1);

        // 4: alarms without valid are ignored
        sat = 1'b1;
        gap(100);
        sat = 1'b0;
        win_gap(0, -1);
        check("unqualified_sat", int'(shift), 0);

        // 5: disable mid-window discards the partial window
        win_gap(2, 1);
        win_gap(2, 2);
        for (int i = 0; i < 8; i++) begin
            valid = 1'b1;
            sat   = 1'b1;
            tick();
        end
        en    = 1'b0;
        valid = 1'b0;
        sat   = 1'b0;
        tick();
        check("dis_state", int'(state), 0);
        check("dis_shift", int'(shift), 2);
        gap(5);
        en = 1'b1;
        gap(2);
        window(2, 3);

        // 6: asynchronous reset in HOLD
        gap(2);
        check("hold_before_rst", int'(state), 3);
`ifdef SDFT_SCALE_STATS_EN
        check("stats_last", int'(sat_cnt_o), 2);
        check("stats_peak", int'(sat_peak_o), 16);
`endif
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_shift", int'(shift), 0);
        check("async_rst_state", int'(state), 0);
        check("async_rst_upd", int'(upd), 0);
`ifdef SDFT_SCALE_STATS_EN
        check("async_rst_peak", int'(sat_peak_o), 0);
`endif
        gap(2);
        rst = 1'b0;
        gap(3);
        check("sb_empty", sbq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
